// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and instruction field positions
// for the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam int OP_MSB = 11;
  localparam int OP_LSB = 9;
  localparam int RD_MSB = 8;
  localparam int RD_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 3;
  localparam int RT_MSB = 2;
  localparam int RT_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction valid/ready channel into the sequencer.
// master = instruction source, slave = sequencer.
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic [11:0] instr;
  logic        instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/seq_regfile.sv
// 8-entry register file: two operand read ports, one debug
// read port, one synchronous write port, async clear.
module seq_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [2:0]       rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] rf_q [8];
  logic [WIDTH-1:0] rf_d [8];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign ra_data  = rf_q[ra_addr];
  assign rb_data  = rf_q[rb_addr];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues register-register ops to an external ALU, waits ALU_LAT
// cycles, writes back. Optional carry flag: ALU_SEQ_CARRY_FLAG_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_sequencer_if.slave ibus,
  input  logic             ld_en,
  input  logic [2:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [2:0]       alu_op,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_r0,
  input  logic             alu_c_out,
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  input  logic [2:0]       rf_raddr,
  output logic [WIDTH-1:0] rf_rdata
`ifdef ALU_SEQ_CARRY_FLAG_EN
  ,
  output logic             carry_flag
`endif
);

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       rd_q, rd_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_r2_q, alu_r2_d;
  logic [WIDTH-1:0] alu_r3_q, alu_r3_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             wb_valid_q, wb_valid_d;
  logic [2:0]       wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic [2:0]       f_op, f_rd, f_rs, f_rt;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             accept, done, ld_wr, ex_wr;
  logic             rf_we;
  logic [2:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] res;

  assign f_op = ibus.instr[OP_MSB:OP_LSB];
  assign f_rd = ibus.instr[RD_MSB:RD_LSB];
  assign f_rs = ibus.instr[RS_MSB:RS_LSB];
  assign f_rt = ibus.instr[RT_MSB:RT_LSB];

  // a same-cycle load takes priority over an offered instruction
  assign ibus.instr_ready = (state_q == S_IDLE) & ~ld_en;
  assign accept = ibus.instr_ready & ibus.instr_valid;
  assign done   = (state_q == S_EXEC) & (cnt_q == LAT_M1);
  assign ld_wr  = (state_q == S_IDLE) & ld_en;
  assign ex_wr  = done & (op_q != OP_NOP);
  assign res    = (op_q == OP_NOP) ? '0 : alu_r0;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      ld_wr: begin
        rf_we    = 1'b1;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
      end
      ex_wr: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res;
      end
      default: ;
    endcase
  end

  seq_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (f_rs),
    .ra_data  (rs_data),
    .rb_addr  (f_rt),
    .rb_data  (rt_data),
    .dbg_addr (rf_raddr),
    .dbg_data (rf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    alu_r2_d   = alu_r2_q;
    alu_r3_d   = alu_r3_q;
    alu_op_d   = alu_op_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d     = f_rd;
          op_d     = f_op;
          cnt_d    = '0;
          alu_r2_d = rs_data;
          alu_r3_d = rt_data;
          alu_op_d = f_op;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (done) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = res;
          state_d    = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_CARRY_FLAG_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (done && (op_q == OP_ADD || op_q == OP_SUB))
      carry_d = alu_c_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign carry_flag = carry_q;
`else
  logic unused_c_out;
  assign unused_c_out = alu_c_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      alu_r2_q   <= '0;
      alu_r3_q   <= '0;
      alu_op_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      alu_r2_q   <= alu_r2_d;
      alu_r3_q   <= alu_r3_d;
      alu_op_q   <= alu_op_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_r2   = alu_r2_q;
  assign alu_r3   = alu_r3_q;
  assign alu_op   = alu_op_q;
  assign alu_c_in = 1'b0;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Initiator-side controller for the N-bit ALU. It accepts 12-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 8-entry register file. It drives the ALU operand and opcode ports, waits a fixed ALU latency, captures the result and writes it back. It sits between an instruction source (bench or fetch stage) and `ALU_Nbit`, and is the block that exercises the ALU in-system.

## Interface
- `WIDTH`, 32: datapath width; matches the ALU `WIDTH`.
- `ALU_LAT`, 1: cycles from ALU input update to a valid `R0`; legal range 1–7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `instr_valid` in 1: instruction offered.
- `instr` in 12: `{op[11:9], rd[8:6], rs[5:3], rt[2:0]}`.
- `instr_ready` out 1: instruction accepted on an edge where `instr_valid & instr_ready`.
- `ld_en` in 1: direct register load; honoured only in IDLE.
- `ld_addr` in 3: load target register.
- `ld_data` in WIDTH: load value.
- `alu_r2` out WIDTH: ALU operand A, registered.
- `alu_r3` out WIDTH: ALU operand B, registered.
- `alu_op` out 3: ALUOp, registered.
- `alu_c_in` out 1: constant 0.
- `alu_r0` in WIDTH: ALU result.
- `alu_c_out` in 1: ALU carry out.
- `wb_valid` out 1: one-cycle pulse when an instruction retires.
- `wb_rd` out 3: destination register of the retiring instruction.
- `wb_data` out WIDTH: value written back.
- `rf_raddr` in 3: debug read address.
- `rf_rdata` out WIDTH: combinational read of `rf[rf_raddr]`; shows the post-write value once the write edge has passed.

## Operation
- Opcodes:
  - 000 MOV (R2)
  - 001 NOT
  - 010 ADD
  - 011 SUB (R2−R3)
  - 100 OR
  - 101 AND
  - 110 SLT (signed, result 0/1)
  - 111 NOP
- Operand mapping: `alu_r2 = rf[rs]`, `alu_r3 = rf[rt]`. `rt` is don't-care for MOV and NOT, but still drives `alu_r3`.
- FSM states: IDLE → EXEC → WB → IDLE.
  - IDLE: `instr_ready = ~ld_en`. On accept, latch `rd`/`op`, load the ALU output registers, clear the latency counter, go to EXEC.
  - EXEC: count ALU_LAT cycles. On the edge where the count reaches ALU_LAT, sample `alu_r0`, write `rf[rd]` (unless NOP), register `wb_*`, go to WB.
  - WB: `wb_valid = 1` for exactly this cycle; next edge returns to IDLE.
- NOP: passes through EXEC/WB with the same timing. `wb_valid` still pulses with `wb_data = 0`. Register file unchanged.
- Load vs instruction in the same IDLE cycle: the load wins and the instruction is not accepted (`instr_ready` is low). The instruction is taken on a later cycle and sees the loaded value.
- `ld_en` outside IDLE is ignored. No write occurs.
- Register overlap (`rd` equal to `rs` or `rt`) is legal. Operands were captured at accept, so there is no hazard.
- A deasserted `instr_valid` is never accepted. `instr` may change freely while it is not accepted.

## Timing
- Accept at edge 0. `alu_*` ports are valid from just after edge 0. Register write at edge ALU_LAT. `wb_valid` is high during cycle ALU_LAT→ALU_LAT+1. `instr_ready` is high again after edge ALU_LAT+1.
- Throughput: one instruction per ALU_LAT+2 cycles.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All `rf` entries, `alu_r2`, `alu_r3`, `alu_op`, `wb_valid`, `wb_rd`, `wb_data` go to 0.
  - `instr_ready` is 1 once `rst_n` is high, provided `ld_en` is low.
- Reset in EXEC or WB abandons the instruction with no write.

## Configuration
- `ALU_SEQ_CARRY_FLAG_EN` defined:
  - Adds output `carry_flag` (1 bit, reset 0).
  - The flag loads `alu_c_out` at the write edge of ADD and SUB only. All other ops hold it.
- Undefined: the port and register are absent. `alu_c_out` is unused.

## Structure
- Package `alu_seq_pkg` holds:
  - Opcode localparams (`OP_MOV` … `OP_NOP`).
  - The FSM state enum.
  - Instruction field bit positions.
- Sub-module `seq_regfile`:
  - 8×WIDTH.
  - Two combinational read ports for operands, plus the debug read port.
  - One synchronous write port, with write muxing between load and writeback done in the parent.
  - Asynchronous active-low clear.

## Test plan
- Reset with `rst_n` low mid-EXEC of ADD r1←r2+r3 → no write, `rf[1]` = 0, `instr_ready` = 1 one cycle after release.
- Load r2=0x0000FFFF, r3=0x00000001; ADD r1,r2,r3 → `wb_valid` at accept+ALU_LAT, `wb_data` = 0x00010000, `rf[1]` = 0x00010000.
- Load r4=0x00000005, r5=0x00000006; SUB r6,r4,r5 → 0xFFFFFFFF. With `ALU_SEQ_CARRY_FLAG_EN`, `carry_flag` equals the sampled `alu_c_out`.
- Load r2=0xFFFFFFFF, r3=0; SLT r7,r2,r3 → 1. SLT r7,r3,r2 → 0.
- `ld_en` and `instr_valid` high together in IDLE → load r3=0x0F0F0F0F first, then NOT r3,r3 → 0xF0F0F0F0.
- NOP back-to-back with AND → NOP `wb_data` = 0, register file unchanged, AND retires ALU_LAT+2 cycles later.
